// File: rtl/barrel_raster_sequencer.sv
// Raster-order coordinate scheduler for the barrel projection output path.
// Issues (X, Y) one per accepted AXIS beat once the line buffer has filled,
// holds on downstream backpressure, pauses when the buffer runs low, and
// keeps frame/stall statistics.
module barrel_raster_sequencer #(
    parameter int unsigned out_width  = 1080,
    parameter int unsigned out_height = 960,
    parameter int unsigned coord_bits = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_stats,
    input  logic                  Buf_Ready,
    input  logic                  Out_tReady,
    output logic [coord_bits-1:0] Coord_X,
    output logic [coord_bits-1:0] Coord_Y,
    output logic                  Coord_Valid,
    output logic                  Frame_Start,
    output logic                  Line_End,
    output logic                  Frame_Done,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic [15:0]           stall_count,
    output logic                  underrun
);

    localparam logic [coord_bits-1:0] x_last    = coord_bits'(out_width - 1);
    localparam logic [coord_bits-1:0] y_last    = coord_bits'(out_height - 1);
    localparam logic [15:0]           stall_max = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FILL = 3'd1,
        RUN       = 3'd2,
        STALL     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [coord_bits-1:0] x_next;
    logic [coord_bits-1:0] y_next;
    logic                  enter_stall;
    logic                  at_eol;
    logic                  at_last;

    assign at_eol  = (Coord_X == x_last);
    assign at_last = at_eol && (Coord_Y == y_last);

    // Next-state and coordinate advance; a beat only advances when accepted.
    always_comb begin
        state_next  = state;
        x_next      = Coord_X;
        y_next      = Coord_Y;
        enter_stall = 1'b0;
        unique case (state)
            IDLE: begin
                x_next = '0;
                y_next = '0;
                if (enable) begin
                    state_next = WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (Buf_Ready) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (Out_tReady) begin
                    if (at_last) begin
                        state_next = DONE;
                        x_next     = '0;
                        y_next     = '0;
                    end else begin
                        if (at_eol) begin
                            x_next = '0;
                            y_next = Coord_Y + coord_bits'(1);
                        end else begin
                            x_next = Coord_X + coord_bits'(1);
                        end
                        if (!Buf_Ready) begin
                            state_next  = STALL;
                            enter_stall = 1'b1;
                        end
                    end
                end
            end
            STALL: begin
                if (Buf_Ready) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                state_next = enable ? WAIT_FILL : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, coordinate and state-decoded output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            Coord_X     <= '0;
            Coord_Y     <= '0;
            Coord_Valid <= 1'b0;
            Frame_Done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            Coord_X     <= x_next;
            Coord_Y     <= y_next;
            Coord_Valid <= (state_next == RUN);
            Frame_Done  <= (state_next == DONE);
            busy        <= (state_next != IDLE);
        end
    end

    // Frame/stall statistics; clear has priority over any same-cycle update.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            frame_count <= '0;
            stall_count <= '0;
            underrun    <= 1'b0;
        end else begin
            if (state == DONE) begin
                frame_count <= frame_count + 16'd1;
            end
            if ((state == STALL) && (stall_count != stall_max)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (enter_stall) begin
                underrun <= 1'b1;
            end
        end
    end

    assign Frame_Start = Coord_Valid && (Coord_X == '0) && (Coord_Y == '0);
    assign Line_End    = Coord_Valid && at_eol;

endmodule

// File: tb/tb_barrel_raster_sequencer.sv
// Self-checking bench for barrel_raster_sequencer (4x3 frame).
module tb_barrel_raster_sequencer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_RUN   = 2;
    localparam int P_STALL = 3;
    localparam int P_DONE  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_stats;
    logic        Buf_Ready;
    logic        Out_tReady;
    logic [11:0] Coord_X;
    logic [11:0] Coord_Y;
    logic        Coord_Valid;
    logic        Frame_Start;
    logic        Line_End;
    logic        Frame_Done;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] stall_count;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    // Reference model: beat index within the frame plus a phase.
    int m_ph;
    int m_idx;
    int m_frames;
    int m_stall;
    int m_under;
    int sb_idx;

    barrel_raster_sequencer #(
        .out_width (W),
        .out_height(H),
        .coord_bits(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_stats(clear_stats),
        .Buf_Ready  (Buf_Ready),
        .Out_tReady (Out_tReady),
        .Coord_X    (Coord_X),
        .Coord_Y    (Coord_Y),
        .Coord_Valid(Coord_Valid),
        .Frame_Start(Frame_Start),
        .Line_End   (Line_End),
        .Frame_Done (Frame_Done),
        .busy       (busy),
        .frame_count(frame_count),
        .stall_count(stall_count),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            m_ph = P_IDLE; m_idx = 0; m_frames = 0; m_stall = 0; m_under = 0;
        end else begin
            case (m_ph)
                P_IDLE:  if (enable) m_ph = P_FILL;
                P_FILL:  if (Buf_Ready) m_ph = P_RUN;
                P_RUN: begin
                    if (Out_tReady) begin
                        if (m_idx == N - 1) begin
                            m_ph = P_DONE;
                            m_idx = 0;
                        end else begin
                            m_idx++;
                            if (!Buf_Ready) begin
                                m_ph = P_STALL;
                                m_under = 1;
                            end
                        end
                    end
                end
                P_STALL: begin
                    if (m_stall < 65535) m_stall++;
                    if (Buf_Ready) m_ph = P_RUN;
                end
                default: begin
                    m_frames = (m_frames + 1) % 65536;
                    m_ph = enable ? P_FILL : P_IDLE;
                end
            endcase
            if (clear_stats) begin
                m_frames = 0; m_stall = 0; m_under = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic v;
        v = (m_ph == P_RUN);
        chk("coord_valid", 32'(Coord_Valid), 32'(v));
        chk("coord_x", 32'(Coord_X), 32'(m_idx % W));
        chk("coord_y", 32'(Coord_Y), 32'(m_idx / W));
        chk("frame_start", 32'(Frame_Start), 32'(v && m_idx == 0));
        chk("line_end", 32'(Line_End), 32'(v && (m_idx % W) == W - 1));
        chk("frame_done", 32'(Frame_Done), 32'(m_ph == P_DONE));
        chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
        chk("frame_count", 32'(frame_count), 32'(m_frames));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("underrun", 32'(underrun), 32'(m_under));
    endtask

    // One clock: scoreboard any accepted beat, then clock, model and compare.
    task automatic step();
        if (Coord_Valid === 1'b1 && Out_tReady && !reset) begin
            chk("sb_x", 32'(Coord_X), 32'(sb_idx % W));
            chk("sb_y", 32'(Coord_Y), 32'(sb_idx / W));
            sb_idx = (sb_idx + 1) % N;
        end
        if (reset) sb_idx = 0;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_until(input int ph, input int idx, input int budget);
        int n;
        n = 0;
        while (!(m_ph == ph && m_idx == idx) && n < budget) begin
            step();
            n++;
        end
        chk("reach_target", 32'(m_ph == ph && m_idx == idx), 32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear_stats = 1'b0;
        Buf_Ready = 1'b0; Out_tReady = 1'b0;
        m_ph = P_IDLE; m_idx = 0; m_frames = 0; m_stall = 0; m_under = 0;
        sb_idx = 0;
        step();
        step();
        chk("rst_valid", 32'(Coord_Valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frame_count), 32'd0);

        // Full frame with no backpressure.
        reset = 1'b0; enable = 1'b1; Buf_Ready = 1'b1; Out_tReady = 1'b1;
        step();
        chk("lat_fill_busy", 32'(busy), 32'd1);
        chk("lat_fill_valid", 32'(Coord_Valid), 32'd0);
        enable = 1'b0;
        step();
        chk("lat_first_valid", 32'(Coord_Valid), 32'd1);
        chk("first_sof", 32'(Frame_Start), 32'd1);
        for (int b = 1; b < N; b++) begin
            step();
            chk("beat_x", 32'(Coord_X), 32'(b % W));
            chk("beat_y", 32'(Coord_Y), 32'(b / W));
            chk("beat_eol", 32'(Line_End), 32'((b % W) == W - 1));
        end
        step();
        chk("done_pulse", 32'(Frame_Done), 32'd1);
        step();
        chk("frames_one", 32'(frame_count), 32'd1);
        chk("idle_after", 32'(busy), 32'd0);

        // Backpressure pattern 1,0,0,1.
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        Out_tReady = 1'b1; step();
        Out_tReady = 1'b0; step();
        chk("bp_hold1_x", 32'(Coord_X), 32'd1);
        step();
        chk("bp_hold2_x", 32'(Coord_X), 32'd1);
        chk("bp_hold2_v", 32'(Coord_Valid), 32'd1);
        Out_tReady = 1'b1; step();
        chk("bp_resume_x", 32'(Coord_X), 32'd2);

        // Underrun: Buf_Ready drops during transfer of (1,1).
        run_until(P_RUN, 5, 40);
        Buf_Ready = 1'b0;
        step();
        chk("stall_entry_v", 32'(Coord_Valid), 32'd0);
        for (int i = 0; i < 4; i++) step();
        Buf_Ready = 1'b1;
        step();
        chk("stall_resume_v", 32'(Coord_Valid), 32'd1);
        chk("stall_resume_x", 32'(Coord_X), 32'd2);
        chk("stall_resume_y", 32'(Coord_Y), 32'd1);
        chk("stall_count5", 32'(stall_count), 32'd5);
        chk("underrun_set", 32'(underrun), 32'd1);

        // Buf_Ready low while beat pending: beat must stay presented.
        Out_tReady = 1'b0; Buf_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pend_valid", 32'(Coord_Valid), 32'd1);
            chk("pend_x", 32'(Coord_X), 32'd2);
        end
        Out_tReady = 1'b1; Buf_Ready = 1'b1;
        run_until(P_IDLE, 0, 40);

        // enable dropped mid-frame completes the frame.
        clear_stats = 1'b1; step(); clear_stats = 1'b0;
        enable = 1'b1;
        run_until(P_RUN, 5, 40);
        enable = 1'b0;
        run_until(P_DONE, 0, 40);
        chk("drop_done", 32'(Frame_Done), 32'd1);
        step();
        chk("drop_idle", 32'(busy), 32'd0);
        chk("drop_frames", 32'(frame_count), 32'd1);

        // Reset mid-frame.
        enable = 1'b1;
        run_until(P_RUN, 8, 40);
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b0;
        chk("mid_rst_valid", 32'(Coord_Valid), 32'd0);
        chk("mid_rst_x", 32'(Coord_X), 32'd0);
        chk("mid_rst_y", 32'(Coord_Y), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frames", 32'(frame_count), 32'd0);

        // Long stall saturates; clear coinciding with DONE zeroes frame_count.
        enable = 1'b1;
        run_until(P_RUN, 2, 40);
        enable = 1'b0; Buf_Ready = 1'b0;
        step();
        for (int i = 0; i < 65540; i++) step();
        chk("stall_sat", 32'(stall_count), 32'h0000FFFF);
        Buf_Ready = 1'b1;
        run_until(P_DONE, 0, 40);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("clr_at_done_frames", 32'(frame_count), 32'd0);
        chk("clr_at_done_stall", 32'(stall_count), 32'd0);
        chk("clr_at_done_under", 32'(underrun), 32'd0);

        // Randomized traffic against the model and scoreboard.
        for (int i = 0; i < 3000; i++) begin
            enable      = ($urandom_range(0, 3) != 0);
            Buf_Ready   = ($urandom_range(0, 9) > 1);
            Out_tReady  = ($urandom_range(0, 3) != 0);
            clear_stats = ($urandom_range(0, 199) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; enable = 1'b0; clear_stats = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_raster_sequencer.md
# barrel_raster_sequencer

Raster-order coordinate scheduler for the barrel projection output path. It waits until the barrel line buffer reports enough rows buffered. It then issues output-frame coordinates (X, Y) one per accepted AXIS beat, freezing on downstream backpressure and pausing cleanly when the buffer runs low. Its Coord_X/Coord_Y/Coord_Valid outputs drive the projection math and the buffer's coordinate/valid inputs. It also reports frame boundaries and stall statistics.

## Interface
- out_width, 1080: pixels per output line
- out_height, 960: lines per output frame
- coord_bits, 12: width of Coord_X/Coord_Y; must satisfy 2^coord_bits ≥ max(out_width, out_height)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- enable  in  1  run frames back-to-back while high; sampled only in IDLE and DONE
- clear_stats  in  1  synchronous clear of frame_count, stall_count, underrun
- Buf_Ready  in  1  line buffer holds ≥ minimum rows (buffer's Math_Ready)
- Out_tReady  in  1  downstream AXIS ready; pipeline freeze when low
- Coord_X  out  coord_bits  output column, 0..out_width-1
- Coord_Y  out  coord_bits  output row, 0..out_height-1
- Coord_Valid  out  1  coordinate valid; also the AXIS tValid of the output stream
- Frame_Start  out  1  Coord_Valid && X==0 && Y==0 (SOF marker)
- Line_End  out  1  Coord_Valid && X==out_width-1 (EOL marker)
- Frame_Done  out  1  one-cycle pulse after the last beat of a frame is accepted
- busy  out  1  state ≠ IDLE
- frame_count  out  16  completed frames, wraps at 2^16
- stall_count  out  16  cycles spent in STALL, saturates at 0xFFFF
- underrun  out  1  sticky: at least one mid-frame stall occurred

## Operation
- States: IDLE, WAIT_FILL, RUN, STALL, DONE. Transfer = Coord_Valid && Out_tReady.
- IDLE: Coord_Valid=0, X=Y=0. enable=1 → WAIT_FILL.
- WAIT_FILL: Coord_Valid=0. Buf_Ready=1 → RUN. Does not count as stall.
- RUN: Coord_Valid=1.
  - No transfer: X, Y and state hold, regardless of Buf_Ready. AXIS rule: valid never drops before acceptance.
  - Transfer at the last pixel (X=out_width-1, Y=out_height-1) → DONE, X=Y=0.
  - Otherwise, transfer with Buf_Ready=0 → advance X/Y, then go to STALL.
  - Otherwise, transfer → advance X/Y.
  - Advance rule: X+1; at X=out_width-1, X←0 and Y+1.
- STALL: Coord_Valid=0, X/Y held. Buf_Ready=1 → RUN. stall_count +1 per cycle spent in STALL (saturating). underrun set on entry.
- DONE: one cycle, Frame_Done=1, frame_count+1. enable=1 → WAIT_FILL; else IDLE.
- enable falling mid-frame does not abort; the current frame completes.
- clear_stats: counters←0, underrun←0. If DONE coincides, frame_count←0 (clear wins).
- Arithmetic: X/Y compare against parameter-1 constants; no overflow paths. Unsigned throughout.

## Timing
- All outputs are registered state/counter values or AND/compare of them; no combinational input→output path.
- Reset values: Coord_X=0, Coord_Y=0, Coord_Valid=0, Frame_Done=0, busy=0, frame_count=0, stall_count=0, underrun=0; state IDLE.
- Reset mid-frame: next cycle is IDLE with all of the above. A partial frame is discarded; the downstream consumer resyncs on Frame_Start.
- Latency from enable rising in IDLE with Buf_Ready=1: WAIT_FILL at cycle+1, first Coord_Valid at cycle+2.
- Throughput: 1 coordinate/cycle while Out_tReady=1 and Buf_Ready=1.
- Last-beat transfer → Frame_Done next cycle.
- Back-to-back frames with Buf_Ready held high: 2 idle cycles (DONE, WAIT_FILL) between frames.
- Buf_Ready returning in STALL: Coord_Valid high the next cycle.

## Test plan
Bench parameters: out_width=4, out_height=3 unless noted.
- Reset, then enable=1 and Buf_Ready=1 with Out_tReady=1 → Coord_Valid rises 2 cycles after enable; 12 beats in order (0,0)…(3,2). Frame_Start on beat 0; Line_End on beats 3, 7, 11. Frame_Done 1 cycle after beat 11; frame_count=1.
- Out_tReady toggled 1,0,0,1 during RUN → X/Y and Coord_Valid held across the low cycles; no skipped or duplicated coordinate.
- Buf_Ready=0 during the transfer of (1,1) → (2,1) is not presented; Coord_Valid=0 for 5 cycles while Buf_Ready is held low; resumes at (2,1) the cycle after Buf_Ready rises. stall_count=5, underrun=1.
- Buf_Ready=0 while Coord_Valid=1 and Out_tReady=0 → Coord_Valid stays 1 and coordinate unchanged until accepted.
- enable dropped at beat 5, then reset asserted at beat 8 of the next run (with enable high again) → first frame completes (Frame_Done pulses), state → IDLE. After reset, all outputs at reset values; frame_count=0.
- Long stall (>65535 cycles, or a forced counter preload) → stall_count saturates at 0xFFFF. clear_stats issued in the same cycle as DONE → frame_count=0.
